// File: rtl/proc_1_nios2_mul_pkg.sv
// proc_1_nios2_mul_pkg: op/state enums and default cell latency for the sequential multiplier
package proc_1_nios2_mul_pkg;
    typedef enum logic [1:0] {OP_MUL, OP_MULXUU, OP_MULXSS, OP_MULXSU} mul_op_e;
    typedef enum logic [2:0] {IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, SUM, DONE} mul_state_e;
    localparam int CELL_LAT_DEFAULT = 1;
endpackage

// File: rtl/proc_1_nios2_mul_combine.sv
// proc_1_nios2_mul_combine: 64-bit product assembly from partial products and signed high-word correction
module proc_1_nios2_mul_combine
    import proc_1_nios2_mul_pkg::*;
(
    input  mul_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] p1,
    input  logic [31:0] p2,
    input  logic [31:0] p3,
    input  logic [31:0] hh,
    output logic [31:0] data
);
    logic [32:0] mid;
    logic [63:0] p;
    always_comb begin
        mid  = {1'b0, p2} + {1'b0, p3};
        p    = {hh, 32'h0} + {15'h0, mid, 16'h0} + {32'h0, p1};
        data = op == OP_MUL    ? p[31:0] :
               op == OP_MULXUU ? p[63:32] :
               op == OP_MULXSS ? p[63:32] - (a[31] ? b : 32'h0) - (b[31] ? a : 32'h0) :
                                 p[63:32] - (a[31] ? b : 32'h0);
    end
endmodule

// File: rtl/proc_1_nios2_gen2_0_cpu_mul_seq.sv
// proc_1_nios2_gen2_0_cpu_mul_seq: sequential 32x32 multiplier sequencing an external 16x16 cell.
// PROC_1_NIOS2_MUL_SEQ_HI_EN enables the high-word ops (MULXUU/MULXSS/MULXSU).
module proc_1_nios2_gen2_0_cpu_mul_seq
    import proc_1_nios2_mul_pkg::*;
#(
    parameter int CELL_LAT = CELL_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);
    localparam logic [1:0] LAST = 2'(CELL_LAT - 1);
    mul_state_e  state;
    mul_op_e     op;
    logic [31:0] a, b, p1, p2, p3, hh, sum_data;
    logic [1:0]  cnt;
    logic        err;
`ifdef PROC_1_NIOS2_MUL_SEQ_HI_EN
    assign err = 1'b0;
`else
    assign err = op != OP_MUL;
    assign hh  = 32'h0;
`endif
    proc_1_nios2_mul_combine u_combine (
        .op(op), .a(a), .b(b), .p1(p1), .p2(p2), .p3(p3), .hh(hh), .data(sum_data)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op        <= OP_MUL;
            {a, b, p1, p2, p3} <= '0;
`ifdef PROC_1_NIOS2_MUL_SEQ_HI_EN
            hh        <= '0;
`endif
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            cell_en   <= 1'b0;
            cell_src1 <= '0;
            cell_src2 <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op        <= mul_op_e'(req_op);
                    a         <= req_a;
                    b         <= req_b;
                    req_ready <= 1'b0;
                    cell_en   <= 1'b1;
                    cell_src1 <= req_a;
                    cell_src2 <= req_b;
                    state     <= ISSUE_LO;
                end
                ISSUE_LO: begin
                    cell_en <= 1'b0;
                    cnt     <= '0;
                    state   <= WAIT_LO;
                end
                WAIT_LO: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == LAST) begin
                        p1 <= cell_p1;
                        p2 <= cell_p2;
                        p3 <= cell_p3;
`ifdef PROC_1_NIOS2_MUL_SEQ_HI_EN
                        if (op != OP_MUL) begin
                            cell_en   <= 1'b1;
                            cell_src1 <= {16'h0, a[31:16]};
                            cell_src2 <= {16'h0, b[31:16]};
                            state     <= ISSUE_HI;
                        end else state <= SUM;
`else
                        state <= SUM;
`endif
                    end
                end
`ifdef PROC_1_NIOS2_MUL_SEQ_HI_EN
                ISSUE_HI: begin
                    cell_en <= 1'b0;
                    cnt     <= '0;
                    state   <= WAIT_HI;
                end
                WAIT_HI: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == LAST) begin
                        hh    <= cell_p1;
                        state <= SUM;
                    end
                end
`endif
                SUM: begin
                    rsp_data  <= err ? 32'h0 : sum_data;
                    rsp_err   <= err;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
